hilo_mult_unit: RTL and testbench
=================================

Name: hilo_mult_unit

Overview:
- Iterative multiply unit that owns the HI/LO register pair for the pipelined MIPS core; executes MULT, MULTU and MADDU.
- Sits beside the EX stage: accepts an operation from EX, computes over several cycles, and drives a stall to the hazard logic when ID needs HI/LO or a second multiply arrives while busy.
- Replaces the single-cycle multiplier in the EX stage.
- Serves MOVE HI / MOVE LO reads.

Parameters:
- RADIX_BITS, 1: multiplier bits retired per iteration. Legal values are 1, 2 and 4.
- N_ITER, 32/RADIX_BITS: derived iteration count. Not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  EX holds a valid MULT/MULTU/MADDU this cycle
- op_i  in  2  operation: 00 MULT (signed), 01 MULTU, 10 MADDU (unsigned accumulate), 11 reserved (treated as no-op)
- src_a_i  in  32  rs operand
- src_b_i  in  32  rt operand
- rd_req_i  in  1  ID holds MOVE HI/MOVE LO
- rd_sel_i  in  1  0 = LO, 1 = HI
- rd_data_o  out  32  selected HI/LO value, combinational from the registers
- hi_o  out  32  HI register
- lo_o  out  32  LO register
- busy_o  out  1  state != IDLE
- stall_o  out  1  (start_i | rd_req_i) & busy_o

Behaviour:
- Reset (synchronous, takes priority everywhere): state = IDLE, HI = 0, LO = 0, internal accumulator/operands = 0, busy_o = 0, stall_o = 0. Reset mid-operation abandons the computation; HI/LO are zeroed, not partially written.
- FSM states: IDLE, CALC, FIX.
- IDLE, start_i & op_i != 11:
  - on edge E0, latch op_i.
  - Latch |src_a_i| and |src_b_i|, taking magnitudes for MULT only.
  - Latch sign = a[31]^b[31] for MULT, else 0.
  - Clear the 64-bit product and the iteration counter. Go to CALC.
- IDLE, op_i = 11: ignored; stays IDLE.
- CALC:
  - Each edge adds the current RADIX_BITS-wide multiplier digit × multiplicand into the product, shifts, and increments the counter.
  - After N_ITER edges (edge E0+N_ITER), go to FIX.
- FIX, one edge (E0+N_ITER+1), then go to IDLE:
  - MULT: {HI,LO} = sign ? -prod : prod.
  - MULTU: {HI,LO} = prod.
  - MADDU: {HI,LO} = {HI,LO} + prod, modulo 2^64 with no overflow flag.
- Latency: busy_o is high for exactly N_ITER+1 cycles after the accept edge. The new HI/LO is visible the cycle after the FIX edge (33 cycles at RADIX_BITS=1).
- start_i while busy:
  - not accepted; stall_o asserted.
  - EX must hold the instruction; it is accepted on the first IDLE cycle.
- rd_req_i while busy: stall_o asserted; rd_data_o shows the old value and must not be consumed.
- start_i and rd_req_i together in IDLE:
  - no stall.
  - The read returns the pre-operation HI/LO; the MOVE is older in program order.
- A MOVE arriving in the cycle after the FIX edge reads the new value; no bypass is required.
- HI/LO change only on the FIX edge or reset.

Optional Feature:
- Macro: HILO_EARLY_ZERO_EN.
- Defined:
  - In IDLE on accept, if src_a_i == 0 or src_b_i == 0, skip CALC.
  - Go directly to FIX with prod = 0, so busy_o is high for 1 cycle.
  - MADDU then leaves HI/LO unchanged, MULT/MULTU write 0.
- Undefined: all operations take N_ITER+1 busy cycles regardless of operands.

Decomposition:
- Shared package hilo_pkg:
  - op encodings OP_MULT, OP_MULTU, OP_MADDU, OP_RSVD
  - state enum IDLE/CALC/FIX
  - constant XLEN = 32
- One natural sub-module, mult_iter_core:
  - Holds the product/multiplicand shift registers and the digit add.
  - Driven by load/step enables from the FSM.
  - Reports the counter at N_ITER-1.
- The parent keeps the FSM, sign handling, HI/LO and the stall logic.

Test Plan:
- MULT 7 × 0xFFFFFFFD (−3), RADIX_BITS=1 → busy_o high 33 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001. Repeat with RADIX_BITS=2 and 4: busy_o high 17 and 9 cycles, same result.
- Preload HI:LO = 0:0xFFFFFFFF via prior MULTU 0xFFFFFFFF × 1, then MADDU 3 × 4 → HI = 1, LO = 0x0000000B (carry into HI).
- rd_req_i=1, rd_sel_i=0 raised 1 cycle after a MULT accept → stall_o = 1 until busy_o falls; next cycle rd_data_o = new LO. A second start_i during busy → stalled, accepted once IDLE, and the result reflects both operations in order.
- rst pulsed at CALC iteration 10 → next cycle busy_o = 0, HI = LO = 0, stall_o = 0. The next MULT 2 × 3 gives LO = 6.
- HILO_EARLY_ZERO_EN defined, MULT 0 × 5 → busy_o high 1 cycle, HI = LO = 0. Undefined → 33 cycles, same result.

Source files
------------

// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encodings, FSM states and width for the HI/LO multiply unit
package hilo_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_MADDU = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/hilo_mult_iter_core.sv
// rtl/hilo_mult_iter_core.sv - radix-2^RADIX_BITS shift-add datapath for the unsigned magnitude product
module mult_iter_core
    import hilo_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [XLEN-1:0]   mcand_i,
    input  logic [XLEN-1:0]   mplier_i,
    output logic [2*XLEN-1:0] prod_o,
    output logic              last_o
);

    localparam int N_ITER = XLEN / RADIX_BITS;
    localparam int CNT_W  = $clog2(N_ITER);

    logic [2*XLEN-1:0]        prod_q, prod_d;
    logic [XLEN-1:0]          mcand_q;
    logic [XLEN-1:0]          mplier_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [XLEN+RADIX_BITS-1:0] partial;
    logic [XLEN+RADIX_BITS-1:0] sum;

    // Right-shifting product: the upper half absorbs digit*mcand, which never exceeds XLEN+RADIX_BITS bits.
    always_comb begin
        partial = (XLEN+RADIX_BITS)'(mplier_q[RADIX_BITS-1:0]) * (XLEN+RADIX_BITS)'(mcand_q);
        sum     = (XLEN+RADIX_BITS)'(prod_q[2*XLEN-1:XLEN]) + partial;
        prod_d  = {sum, prod_q[XLEN-1:RADIX_BITS]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (load_i) begin
            prod_q   <= '0;
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            cnt_q    <= '0;
        end else if (step_i) begin
            prod_q   <= prod_d;
            mplier_q <= mplier_q >> RADIX_BITS;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign prod_o = prod_q;
    assign last_o = (cnt_q == CNT_W'(N_ITER - 1));

endmodule

// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - iterative MULT/MULTU/MADDU unit owning HI/LO, with EX/ID stall
// Optional HILO_EARLY_ZERO_EN: a zero operand skips the iteration phase.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic            rd_req_i,
    input  logic            rd_sel_i,
    output logic [XLEN-1:0] rd_data_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output logic            busy_o,
    output logic            stall_o
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic              sign_q;
    logic [XLEN-1:0]   hi_q, lo_q;
    logic [2*XLEN-1:0] hilo_d;
    logic [2*XLEN-1:0] prod;
    logic              accept, zero_opnd, is_mult, last;
    logic              load_en, step_en, hilo_we;

    assign is_mult = (op_i == OP_MULT);
    assign accept  = start_i && (op_i != OP_RSVD);

`ifdef HILO_EARLY_ZERO_EN
    assign zero_opnd = (src_a_i == '0) || (src_b_i == '0);
`else
    assign zero_opnd = 1'b0;
`endif

    mult_iter_core #(
        .RADIX_BITS (RADIX_BITS)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_en),
        .step_i   (step_en),
        .mcand_i  (is_mult ? magnitude(src_a_i) : src_a_i),
        .mplier_i (is_mult ? magnitude(src_b_i) : src_b_i),
        .prod_o   (prod),
        .last_o   (last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = zero_opnd ? FIX : CALC;
            CALC:    if (last)   state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_en = (state_q == IDLE) && accept;
        step_en = (state_q == CALC);
        hilo_we = (state_q == FIX);
        busy_o  = (state_q != IDLE);
    end

    always_comb begin
        hilo_d = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  hilo_d = sign_q ? (~prod + 64'd1) : prod;
            OP_MULTU: hilo_d = prod;
            OP_MADDU: hilo_d = {hi_q, lo_q} + prod;
            default:  hilo_d = {hi_q, lo_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_MULT;
            sign_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            if (load_en) begin
                op_q   <= op_e'(op_i);
                sign_q <= is_mult && (src_a_i[XLEN-1] ^ src_b_i[XLEN-1]);
            end
            if (hilo_we) begin
                hi_q <= hilo_d[2*XLEN-1:XLEN];
                lo_q <= hilo_d[XLEN-1:0];
            end
        end
    end

    // MOVE in the same IDLE cycle as an accept is older, so it reads pre-operation HI/LO.
    assign rd_data_o = rd_sel_i ? hi_q : lo_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign stall_o   = (start_i || rd_req_i) && busy_o;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - directed self-checking bench for hilo_mult_unit at radix 1, 2 and 4
module tb_hilo_mult_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i, src_b_i;
    logic        rd_req_i, rd_sel_i;

    logic [31:0] rd1, hi1, lo1, rd2, hi2, lo2, rd4, hi4, lo4;
    logic        busy1, stall1, busy2, stall2, busy4, stall4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_mult_unit #(.RADIX_BITS(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd1), .hi_o(hi1), .lo_o(lo1),
        .busy_o(busy1), .stall_o(stall1));

    hilo_mult_unit #(.RADIX_BITS(2)) dut_r2 (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd2), .hi_o(hi2), .lo_o(lo2),
        .busy_o(busy2), .stall_o(stall2));

    hilo_mult_unit #(.RADIX_BITS(4)) dut_r4 (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .src_a_i(src_a_i), .src_b_i(src_b_i),
        .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd4), .hi_o(hi4), .lo_o(lo4),
        .busy_o(busy4), .stall_o(stall4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles per instance; returns at the first negedge with all three idle.
    task automatic wait_idle(output int c1, output int c2, output int c4);
        int guard;
        c1 = 0; c2 = 0; c4 = 0; guard = 0;
        while ((busy1 || busy2 || busy4) && guard < 200) begin
            if (busy1) c1++;
            if (busy2) c2++;
            if (busy4) c4++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("busy_timeout", 64'(guard), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int c1, output int c2, output int c4);
        @(negedge clk);
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        @(negedge clk);
        start_i = 1'b0;
        wait_idle(c1, c2, c4);
    endtask

    int c1, c2, c4, good, n;

    initial begin
        rst = 1'b1; start_i = 1'b0; op_i = 2'b00; src_a_i = '0; src_b_i = '0;
        rd_req_i = 1'b0; rd_sel_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy",  64'(busy1),  64'd0);
        check("rst_stall", 64'(stall1), 64'd0);
        check("rst_hilo",  {hi1, lo1},  64'd0);

        // MULT 7 x -3 = -21
        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, c1, c2, c4);
        check("mult_busy", 64'(c1), 64'd33);
        check("mult_hilo", {hi1, lo1}, 64'hFFFF_FFFF_FFFF_FFEB);

        // MULTU all-ones squared across radices
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c1, c2, c4);
        check("multu_busy_r1", 64'(c1), 64'd33);
        check("multu_busy_r2", 64'(c2), 64'd17);
        check("multu_busy_r4", 64'(c4), 64'd9);
        check("multu_hilo_r1", {hi1, lo1}, 64'hFFFF_FFFE_0000_0001);
        check("multu_hilo_r2", {hi2, lo2}, 64'hFFFF_FFFE_0000_0001);
        check("multu_hilo_r4", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);

        // MADDU carry into HI
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, c1, c2, c4);
        check("preload_hilo", {hi1, lo1}, 64'h0000_0000_FFFF_FFFF);
        run_op(2'b10, 32'd3, 32'd4, c1, c2, c4);
        check("maddu_hilo", {hi1, lo1}, 64'h0000_0001_0000_000B);
        rd_sel_i = 1'b1; #1;
        check("rd_hi", 64'(rd1), 64'd1);

        // Signed corner cases
        run_op(2'b00, 32'h8000_0000, 32'd2, c1, c2, c4);
        check("mult_minint", {hi1, lo1}, 64'hFFFF_FFFF_0000_0000);
        run_op(2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFB, c1, c2, c4);
        check("mult_negneg", {hi1, lo1}, 64'd20);

        // Reserved op is ignored
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b11; src_a_i = 32'd9; src_b_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        check("rsvd_busy", 64'(busy1), 64'd0);
        check("rsvd_hilo", {hi1, lo1}, 64'd20);

        // MOVE stalls during MULT; queued MADDU accepted on first idle cycle
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd2; src_b_i = 32'd5;
        @(negedge clk);
        rd_req_i = 1'b1; rd_sel_i = 1'b0;
        op_i = 2'b10; src_a_i = 32'd3; src_b_i = 32'd3;
        #1;
        good = 0; n = 0;
        while (busy1 && n < 100) begin
            if (stall1 && rd1 == 32'd20) good++;
            n++;
            @(negedge clk); #1;
        end
        check("stall_cycles", 64'(good), 64'd33);
        check("idle_stall",   64'(stall1), 64'd0);
        check("rd_new_lo",    64'(rd1), 64'd10);
        @(negedge clk);
        start_i = 1'b0; rd_req_i = 1'b0;
        check("queued_accept", 64'(busy1), 64'd1);
        wait_idle(c1, c2, c4);
        check("queued_busy", 64'(c1), 64'd33);
        check("queued_hilo", {hi1, lo1}, 64'd19);

        // Reset mid-CALC
        @(negedge clk);
        start_i = 1'b1; op_i = 2'b00; src_a_i = 32'd9; src_b_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 64'(busy1), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rd_req_i = 1'b1; rd_sel_i = 1'b1;
        #1;
        check("midrst_busy",  64'(busy1),  64'd0);
        check("midrst_stall", 64'(stall1), 64'd0);
        check("midrst_hilo",  {hi1, lo1},  64'd0);
        rd_req_i = 1'b0;
        run_op(2'b00, 32'd2, 32'd3, c1, c2, c4);
        check("post_rst_mult", {hi1, lo1}, 64'd6);

        // Zero operand: short path only with the early-zero build
        run_op(2'b00, 32'd0, 32'd5, c1, c2, c4);
`ifdef HILO_EARLY_ZERO_EN
        check("zero_busy", 64'(c1), 64'd1);
`else
        check("zero_busy", 64'(c1), 64'd33);
`endif
        check("zero_hilo", {hi1, lo1}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
